// File: rtl/car_field_pkg.sv
// Shared types and helpers for the Frogger car field: lane direction,
// LFSR constants and the single-lane shift used by every lane instance.
package car_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest lane the shift helper supports; lanes use the low WIDTH bits
  localparam int unsigned SHIFT_MAX_W = 64;

  function automatic logic [SHIFT_MAX_W-1:0] lane_shift(
    input logic [SHIFT_MAX_W-1:0] old,
    input int unsigned            width,
    input dir_e                   dir,
    input logic                   entry
  );
    logic [SHIFT_MAX_W-1:0] mask;
    logic [SHIFT_MAX_W-1:0] r;
    mask = '1;
    mask = mask >> (SHIFT_MAX_W - width);
    if (dir == DIR_RIGHT) begin
      r = ((old << 1) | SHIFT_MAX_W'(entry)) & mask;
    end else begin
      r = ((old & mask) >> 1) | (SHIFT_MAX_W'(entry) << (width - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/car_field_lane.sv
// One car lane: step-period counter, circular shift register and the
// registered step pulse that lines up with the shifted cells.
module car_lane
  import car_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] init,
  input  logic             dir,
  input  logic [DIV_W-1:0] period,
  input  logic             entry,
  output logic [WIDTH-1:0] cells,
  output logic             step,
  output logic             shift_now
);

  logic [DIV_W-1:0]       cnt;
  logic                   due;
  logic [SHIFT_MAX_W-1:0] shifted;

  // ">=" rather than "==" so a period shortened mid-count fires at once
  assign due       = (period != '0) && (cnt >= period - DIV_W'(1));
  assign shift_now = !clear && !hold && due;
  assign shifted   = lane_shift(SHIFT_MAX_W'(cells), WIDTH, dir_e'(dir), entry);

  always_ff @(posedge clk) begin
    if (clear) begin
      cells <= init;
      cnt   <= '0;
      step  <= 1'b0;
    end else if (hold) begin
      step <= 1'b0;
    end else if (period == '0) begin
      step <= 1'b0;
    end else if (due) begin
      cells <= shifted[WIDTH-1:0];
      cnt   <= '0;
      step  <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      step <= 1'b0;
    end
  end

  if (WIDTH < SHIFT_MAX_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^shifted[SHIFT_MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/car_field.sv
// Frogger road of LANES shifting car lanes with sticky frog collision flag.
// Define CAR_FIELD_LFSR_EN to feed lane entry bits from a 16-bit LFSR.
module car_field
  import car_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       round_reset,
  input  logic                       hold,
  input  logic [LANES*WIDTH-1:0]     pattern,
  input  logic [LANES-1:0]           dir,
  input  logic [LANES*DIV_W-1:0]     period,
  input  logic                       frog_valid,
  input  logic [$clog2(LANES)-1:0]   frog_lane,
  input  logic [$clog2(WIDTH)-1:0]   frog_col,
  output logic [LANES*WIDTH-1:0]     cells,
  output logic [LANES-1:0]           step,
  output logic                       hit
);

  logic             clear;
  logic [LANES-1:0] entry;
  logic [LANES-1:0] shift_now;
  logic             hit_now;

  assign clear = reset | round_reset;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    car_lane #(
      .WIDTH(WIDTH),
      .DIV_W(DIV_W)
    ) u_lane (
      .clk      (clk),
      .clear    (clear),
      .hold     (hold),
      .init     (pattern[k*WIDTH +: WIDTH]),
      .dir      (dir[k]),
      .period   (period[k*DIV_W +: DIV_W]),
      .entry    (entry[k]),
      .cells    (cells[k*WIDTH +: WIDTH]),
      .step     (step[k]),
      .shift_now(shift_now[k])
    );
  end

`ifdef CAR_FIELD_LFSR_EN
  logic [15:0] lfsr;

  // Only a hard reset reseeds, so traffic keeps varying across rounds
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (|shift_now) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_entry
    assign entry[k] = lfsr[k % 16];
  end
`else
  logic unused_shift;
  assign unused_shift = |shift_now;

  for (genvar k = 0; k < LANES; k++) begin : g_entry
    assign entry[k] = dir[k] ? cells[k*WIDTH + WIDTH - 1] : cells[k*WIDTH];
  end
`endif

  // Only in-range coordinates are enumerated, so out-of-range frogs never hit
  always_comb begin
    hit_now = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned c = 0; c < WIDTH; c++) begin
        if (frog_valid && (32'(frog_lane) == l) && (32'(frog_col) == c)) begin
          hit_now = hit_now | cells[l*WIDTH + c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      hit <= 1'b0;
    end else if (hit_now) begin
      hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_car_field.sv
// Self-checking bench for car_field: directed scenarios followed by random
// traffic, all compared against a rotate-based reference model.
module tb_car_field;

  localparam int W = 8;
  localparam int L = 4;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset, round_reset, hold;
  logic [L*W-1:0] pattern;
  logic [L-1:0]   dir;
  logic [L*D-1:0] period;
  logic           frog_valid;
  logic [1:0]     frog_lane;
  logic [2:0]     frog_col;
  logic [L*W-1:0] cells;
  logic [L-1:0]   step;
  logic           hit;

  car_field #(.WIDTH(W), .LANES(L), .DIV_W(D)) dut (
    .clk(clk), .reset(reset), .round_reset(round_reset), .hold(hold),
    .pattern(pattern), .dir(dir), .period(period),
    .frog_valid(frog_valid), .frog_lane(frog_lane), .frog_col(frog_col),
    .cells(cells), .step(step), .hit(hit)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_cells [L];
  int           m_elapsed [L];
  logic [L-1:0] m_step;
  logic         m_hit;
  logic [15:0]  m_lfsr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [L*W-1:0] model_flat();
    logic [L*W-1:0] f;
    for (int k = 0; k < L; k++) f[k*W +: W] = m_cells[k];
    return f;
  endfunction

  // One clock edge of the road, derived from the behavioural rules
  task automatic model_edge();
    logic [15:0] lf0;
    logic        any;
    logic        e;
    int          p;
    lf0 = m_lfsr;
    any = 1'b0;
    if (reset || round_reset) begin
      for (int k = 0; k < L; k++) begin
        m_cells[k]   = pattern[k*W +: W];
        m_elapsed[k] = 0;
      end
      m_step = '0;
      m_hit  = 1'b0;
      if (reset) m_lfsr = 16'hACE1;
    end else begin
      if (frog_valid && m_cells[frog_lane][frog_col]) m_hit = 1'b1;
      if (hold) begin
        m_step = '0;
      end else begin
        for (int k = 0; k < L; k++) begin
          p = int'(period[k*D +: D]);
          m_step[k] = 1'b0;
          if (p != 0) begin
            if (m_elapsed[k] + 1 >= p) begin
`ifdef CAR_FIELD_LFSR_EN
              e = lf0[k % 16];
`else
              e = dir[k] ? m_cells[k][W-1] : m_cells[k][0];
`endif
              if (dir[k]) m_cells[k] = {m_cells[k][W-2:0], e};
              else        m_cells[k] = {e, m_cells[k][W-1:1]};
              m_elapsed[k] = 0;
              m_step[k]    = 1'b1;
              any          = 1'b1;
            end else begin
              m_elapsed[k]++;
            end
          end
        end
      end
      if (any) m_lfsr = {lf0[14:0], lf0[15] ^ lf0[13] ^ lf0[12] ^ lf0[10]};
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("cells", 64'(cells), 64'(model_flat()));
    check("step",  64'(step),  64'(m_step));
    check("hit",   64'(hit),   64'(m_hit));
`ifdef CAR_FIELD_LFSR_EN
    check("lfsr",  64'(dut.lfsr), 64'(m_lfsr));
`endif
  endtask

  logic [L*W-1:0] snap;
  int             guard;

  initial begin
    reset       = 1'b1;
    round_reset = 1'b0;
    hold        = 1'b0;
    pattern     = {8'b00000001, 8'b10100101, 8'b00010000, 8'b00000011};
    dir         = 4'b0101;
    period      = {8'd1, 8'd0, 8'd2, 8'd3};
    frog_valid  = 1'b0;
    frog_lane   = '0;
    frog_col    = '0;
    m_step      = '0;
    m_hit       = 1'b0;
    m_lfsr      = '0;
    for (int k = 0; k < L; k++) begin
      m_cells[k]   = '0;
      m_elapsed[k] = 0;
    end

    // Reset state
    tick();
    check("reset_cells", 64'(cells), 64'(pattern));
    check("reset_step",  64'(step),  64'd0);
    check("reset_hit",   64'(hit),   64'd0);
`ifdef CAR_FIELD_LFSR_EN
    check("lfsr_seed", 64'(dut.lfsr), 64'h0000_0000_0000_ACE1);
`endif
    reset = 1'b0;

    // First steps, wrap-around, stationary lane
    for (int c = 1; c <= 22; c++) begin
      tick();
`ifndef CAR_FIELD_LFSR_EN
      if (c == 1) check("wrap_left", 64'(cells[3*W +: W]), 64'(8'b10000000));
      if (c == 3) check("lane0_c3",  64'(cells[0 +: W]),   64'(8'b00000110));
      if (c == 6) check("lane0_c6",  64'(cells[0 +: W]),   64'(8'b00001100));
      check("popcount3", 64'($countones(cells[3*W +: W])), 64'd1);
`endif
      if (c == 3 || c == 6) check("step0_pulse", 64'(step[0]), 64'd1);
      check("lane2_static", 64'(cells[2*W +: W]), 64'(8'b10100101));
      check("step2_zero",   64'(step[2]),         64'd0);
    end

    // Hold across a due step of lane 0
    guard = 0;
    while (m_elapsed[0] != 2 && guard < 5) begin
      tick();
      guard++;
    end
    hold = 1'b1;
    snap = model_flat();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_cells", 64'(cells), 64'(snap));
      check("hold_step",  64'(step),  64'd0);
    end
    hold = 1'b0;
    tick();
    check("release_step0", 64'(step[0]), 64'd1);

    // Collision, stickiness, round_reset
    period[1*D +: D] = 8'd0;
    round_reset = 1'b1;
    tick();
    round_reset = 1'b0;
    frog_valid  = 1'b1;
    frog_lane   = 2'd1;
    frog_col    = 3'd4;
    tick();
    check("hit_set", 64'(hit), 64'd1);
    frog_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hit_sticky", 64'(hit), 64'd1);
    end
    round_reset = 1'b1;
    tick();
    check("rr_hit",   64'(hit),   64'd0);
    check("rr_cells", 64'(cells), 64'(pattern));
    round_reset = 1'b0;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 15) == 0) period[k*D +: D] = 8'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 7) == 0) dir = 4'($urandom);
      hold        = ($urandom_range(0, 7) == 0);
      round_reset = ($urandom_range(0, 63) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) pattern = 32'($urandom);
      frog_valid  = 1'($urandom);
      frog_lane   = 2'($urandom);
      frog_col    = 3'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
